// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritises exception, memory wait, divide, redirect and load-use
// into per-register stall/flush and PC hold, sequences the divide stall, keeps perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             div_start,
  input  logic             redirect,
  input  logic             exception,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic [3:0]       stall,
  output logic [3:0]       flush,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned CW = $clog2(DIV_LAT);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_DIV = 1'b1;

  logic [0:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          mem_wait;
  logic          in_div;
  logic          cnt_zero;
  logic          div_stall;
  logic          honor_flush;

  assign mem_wait  = mem_req & ~mem_ack;
  assign in_div    = (state == S_DIV);
  assign cnt_zero  = (cnt == '0);
  assign div_stall = (~in_div & div_start) | (in_div & ~cnt_zero);

  always_comb begin
    pc_stall    = 1'b0;
    stall       = '0;
    flush       = '0;
    honor_flush = 1'b0;
    if (exception) begin
      flush       = '1;
      honor_flush = 1'b1;
    end else if (mem_wait) begin
      stall    = 4'b0111;
      flush    = 4'b1000;
      pc_stall = 1'b1;
    end else if (div_stall) begin
      stall    = 4'b0011;
      flush    = 4'b0100;
      pc_stall = 1'b1;
    end else if (~in_div & redirect) begin
      flush       = 4'b0011;
      honor_flush = 1'b1;
    end else if (~in_div & load_use) begin
      stall    = 4'b0001;
      flush    = 4'b0010;
      pc_stall = 1'b1;
    end
    div_done = in_div & cnt_zero & ~mem_wait & ~exception;
    // Reset overrides the decode so every pipeline register is bubbled while held.
    if (rst) begin
      pc_stall    = 1'b1;
      stall       = '0;
      flush       = '1;
      div_done    = 1'b0;
      honor_flush = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (exception) begin
      state_nx = S_RUN;
      cnt_nx   = '0;
    end else if (!in_div) begin
      if (div_start && !mem_wait) begin
        state_nx = S_DIV;
        cnt_nx   = CW'(DIV_LAT - 2);
      end
    end else if (!mem_wait) begin
      if (cnt_zero) state_nx = S_RUN;
      else          cnt_nx   = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      stall_cycles <= stall_cycles + CNT_W'(pc_stall);
      flush_events <= flush_events + CNT_W'(honor_flush);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DIV_LAT = 8;
  localparam int unsigned CNT_W   = 32;

  logic             clk, rst;
  logic             load_use, div_start, redirect, exception, mem_req, mem_ack;
  logic             pc_stall, div_done;
  logic [3:0]       stall, flush;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .div_start(div_start),
    .redirect(redirect), .exception(exception), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .stall(stall), .flush(flush), .div_done(div_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a divide is "busy" with m_left non-waiting cycles to go, the last being the done cycle.
  bit               m_busy;
  int               m_left;
  logic [CNT_W-1:0] m_sc, m_fe;
  logic             e_pc, e_dd, e_honor;
  logic [3:0]       e_st, e_fl;

  function automatic void model_out();
    bit mw, done_now;
    mw       = mem_req && !mem_ack;
    done_now = m_busy && (m_left == 1) && !mw;
    e_pc = 0; e_st = 4'b0000; e_fl = 4'b0000; e_dd = 0; e_honor = 0;
    if (rst) begin
      e_pc = 1; e_fl = 4'b1111;
    end else begin
      if (exception) begin
        e_fl = 4'b1111; e_honor = 1;
      end else if (mw) begin
        e_st = 4'b0111; e_fl = 4'b1000; e_pc = 1;
      end else if ((!m_busy && div_start) || (m_busy && !done_now)) begin
        e_st = 4'b0011; e_fl = 4'b0100; e_pc = 1;
      end else if (!m_busy && redirect) begin
        e_fl = 4'b0011; e_honor = 1;
      end else if (!m_busy && load_use) begin
        e_st = 4'b0001; e_fl = 4'b0010; e_pc = 1;
      end
      e_dd = done_now && !exception;
    end
  endfunction

  function automatic void model_edge();
    bit mw;
    mw = mem_req && !mem_ack;
    if (rst) begin
      m_busy = 0; m_left = 0; m_sc = '0; m_fe = '0;
    end else begin
      m_sc = m_sc + (e_pc ? 1 : 0);
      m_fe = m_fe + (e_honor ? 1 : 0);
      if (exception) m_busy = 0;
      else if (!m_busy) begin
        if (div_start && !mw) begin m_busy = 1; m_left = DIV_LAT - 1; end
      end else if (!mw) begin
        if (m_left == 1) m_busy = 0;
        else m_left = m_left - 1;
      end
    end
  endfunction

  function automatic string got_s();
    return $sformatf("pc=%b st=%b fl=%b dd=%b sc=%0d fe=%0d", pc_stall, stall, flush, div_done, stall_cycles, flush_events);
  endfunction
  function automatic string exp_s();
    return $sformatf("pc=%b st=%b fl=%b dd=%b sc=%0d fe=%0d", e_pc, e_st, e_fl, e_dd, m_sc, m_fe);
  endfunction

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic drive(input logic r, li, ds, rd, ex, mr, ma);
    rst = r; load_use = li; div_start = ds; redirect = rd; exception = ex; mem_req = mr; mem_ack = ma;
    #2;
    model_out();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0); tick(); end
    // mid-divide reset: outputs and counters respond without waiting for an edge
    drive(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (pc_stall !== 1'b1 || stall !== 4'b0000 || flush !== 4'b1111 || div_done !== 1'b0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_mid_div got %s exp pc=1 st=0000 fl=1111 dd=0 sc=0", got_s());
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if ({pc_stall, stall, flush, div_done} !== 10'b0 || stall_cycles !== '0 || flush_events !== '0) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got %s exp all zero", i, got_s());
      end
      tick();
    end
  endtask

  task automatic test_divide();
    int done_at, done_n;
    logic [CNT_W-1:0] sc0;
    done_at = -1; done_n = 0; sc0 = stall_cycles;
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      drive(0, 0, (i == 0), 0, 0, 0, 0);
      n_tests++;
      if ({pc_stall, stall, flush, div_done} !== {e_pc, e_st, e_fl, e_dd} || stall_cycles !== m_sc || flush_events !== m_fe) begin
        n_fail++; $display("FAIL divide cyc=%0d got %s exp %s", i, got_s(), exp_s());
      end
      if (div_done === 1'b1) begin done_n++; if (done_at < 0) done_at = i; end
      tick();
    end
    n_tests++;
    if (done_at != DIV_LAT - 1 || done_n != 1 || stall_cycles - sc0 !== CNT_W'(DIV_LAT - 1)) begin
      n_fail++; $display("FAIL divide_timing got done_at=%0d n=%0d stalls=%0d exp done_at=%0d n=1 stalls=%0d",
                         done_at, done_n, stall_cycles - sc0, DIV_LAT - 1, DIV_LAT - 1);
    end
  endtask

  task automatic test_div_memwait();
    int done_at;
    done_at = -1;
    for (int i = 0; i < DIV_LAT + 5; i++) begin
      drive(0, 0, (i == 0), 0, 0, (i == 2 || i == 3), 0);
      n_tests++;
      if ({pc_stall, stall, flush, div_done} !== {e_pc, e_st, e_fl, e_dd} || stall_cycles !== m_sc || flush_events !== m_fe) begin
        n_fail++; $display("FAIL div_memwait cyc=%0d got %s exp %s", i, got_s(), exp_s());
      end
      if ((i == 2 || i == 3) && (stall !== 4'b0111 || flush !== 4'b1000)) begin
        n_fail++; $display("FAIL div_memwait_rows cyc=%0d got st=%b fl=%b exp st=0111 fl=1000", i, stall, flush);
      end
      if (div_done === 1'b1 && done_at < 0) done_at = i;
      tick();
    end
    n_tests++;
    if (done_at != DIV_LAT + 1) begin
      n_fail++; $display("FAIL div_memwait_done got %0d exp %0d", done_at, DIV_LAT + 1);
    end
  endtask

  task automatic test_div_exception();
    int done_n;
    logic [CNT_W-1:0] fe0;
    done_n = 0; fe0 = flush_events;
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      drive(0, 0, (i == 0), 0, (i == 2), 0, 0);
      n_tests++;
      if ({pc_stall, stall, flush, div_done} !== {e_pc, e_st, e_fl, e_dd} || stall_cycles !== m_sc || flush_events !== m_fe) begin
        n_fail++; $display("FAIL div_exc cyc=%0d got %s exp %s", i, got_s(), exp_s());
      end
      if (i == 3 && {pc_stall, stall, flush} !== 9'b0) begin
        n_fail++; $display("FAIL div_exc_idle got %s exp all zero", got_s());
      end
      if (div_done === 1'b1) done_n++;
      tick();
    end
    n_tests++;
    if (done_n != 0 || flush_events - fe0 !== CNT_W'(1)) begin
      n_fail++; $display("FAIL div_exc_summary got done_n=%0d fe_delta=%0d exp 0 1", done_n, flush_events - fe0);
    end
  endtask

  task automatic test_priority();
    logic [CNT_W-1:0] fe0;
    fe0 = flush_events;
    drive(0, 0, 0, 1, 0, 1, 0);
    n_tests++;
    if (stall !== 4'b0111 || flush !== 4'b1000 || pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL prio_memwait got %s exp pc=1 st=0111 fl=1000", got_s());
    end
    tick();
    drive(0, 0, 0, 1, 0, 1, 1);
    n_tests++;
    if (flush !== 4'b0011 || stall !== 4'b0000 || pc_stall !== 1'b0 || flush_events !== fe0) begin
      n_fail++; $display("FAIL prio_redirect got %s exp pc=0 st=0000 fl=0011 fe=%0d", got_s(), fe0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (flush_events - fe0 !== CNT_W'(1)) begin
      n_fail++; $display("FAIL prio_count got fe_delta=%0d exp 1", flush_events - fe0);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (stall !== 4'b0001 || flush !== 4'b0010 || pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL load_use got %s exp pc=1 st=0001 fl=0010", got_s());
    end
    tick();
    drive(0, 1, 0, 1, 0, 0, 0);
    n_tests++;
    if (flush !== 4'b0011 || stall !== 4'b0000 || pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL load_use_redirect got %s exp pc=0 st=0000 fl=0011", got_s());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
            ($urandom_range(4) == 0), ($urandom_range(24) == 0), ($urandom_range(3) == 0),
            ($urandom_range(2) == 0));
      n_tests++;
      if ({pc_stall, stall, flush, div_done} !== {e_pc, e_st, e_fl, e_dd} || stall_cycles !== m_sc || flush_events !== m_fe) begin
        n_fail++; $display("FAIL random cyc=%0d got %s exp %s", i, got_s(), exp_s());
      end
      tick();
    end
  endtask

  initial begin
    m_busy = 0; m_left = 0; m_sc = '0; m_fe = '0;
    test_reset();
    test_divide();
    test_div_memwait();
    test_div_exception();
    test_priority();
    test_load_use();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
